// File: rtl/trng_byte_feeder.sv
// trng_byte_feeder: packs entropy bits MSB-first into bytes, queues them
// in a small FIFO and hands them one per frame to the UART transmitter.
module trng_byte_feeder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  tx_busy,
    output logic                  tx_send,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int TW    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];
    localparam logic [TW-1:0]       T_LAST   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  send_d;
    logic [7:0]            data_d;
    logic                  terr_d;

    logic [2:0]            bit_cnt;
    logic [6:0]            shift;
    logic [7:0]            new_byte;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr, rptr;
    logic [7:0]            head;
    logic                  accept, push, pop, full, empty, wr_en;

    assign accept   = enable & bit_valid;
    assign new_byte = {shift, bit_in};
    assign push     = accept & (bit_cnt == 3'd7);
    assign full     = (fifo_count == FULL_LVL);
    assign empty    = (fifo_count == '0);
    // A pop in the same cycle frees the slot the push lands in.
    assign wr_en    = push & (~full | pop);
    assign head     = mem[rptr[DEPTH_LOG2-1:0]];

    // Bit packer: shift in accepted bits, wrap after the eighth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (accept) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= new_byte[6:0];
        end
    end

    // FIFO storage; contents are invalidated by the pointer reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[DEPTH_LOG2-1:0]] <= new_byte;
    end

    // FIFO pointers, fill level and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            if (wr_en & ~pop)      fifo_count <= fifo_count + 1'b1;
            else if (~wr_en & pop) fifo_count <= fifo_count - 1'b1;
            if (push & ~wr_en) overflow <= 1'b1;
        end
    end

    // Send FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            tx_send     <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tx_send     <= send_d;
            tx_data     <= data_d;
            timeout_err <= terr_d;
        end
    end

    // Send FSM next-state: pop and request, await busy, await idle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        send_d  = 1'b0;
        data_d  = tx_data;
        terr_d  = timeout_err;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    data_d  = head;
                    send_d  = 1'b1;
                    timer_d = '0;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (tx_busy) begin
                    state_d = DONE;
                end else if (timer_q == T_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trng_byte_feeder.sv
// Directed bench for trng_byte_feeder: packing, FIFO, handshake,
// overflow, timeout and asynchronous reset behaviour.
module tb_trng_byte_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       bit_in;
    logic       bit_valid;
    logic       tx_busy;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       timeout_err;

    logic       busy_drv;
    logic       model_on;
    logic       m_busy;
    logic       m_dly;
    int         m_cnt;
    int         cyc;
    int         passed;
    int         total;
    int         failed;
    logic [7:0] sq[$];
    int         tq[$];

    trng_byte_feeder #(.DEPTH_LOG2(4), .ACK_TIMEOUT(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .tx_busy(tx_busy),
        .tx_send(tx_send),
        .tx_data(tx_data),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign tx_busy = model_on ? m_busy : busy_drv;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy rises two edges after send, stays 10 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_dly  <= 1'b0;
            m_cnt  <= 0;
        end else if (model_on) begin
            m_dly <= tx_send;
            if (m_dly) begin
                m_busy <= 1'b1;
                m_cnt  <= 9;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    // Record every send pulse with its data and cycle.
    always @(posedge clk) begin
        if (rst_n && tx_send) begin
            sq.push_back(tx_data);
            tq.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        enable    = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic wait_send(input int max, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            if (tx_send) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_q(input int n, input int max, input string tag);
        for (int i = 0; i < max && sq.size() < n; i++) step();
        chk(tag, 32'(sq.size()), 32'(n));
    endtask

    initial begin
        int nsend;
        logic [7:0] exp_b;
        cyc       = 0;
        passed    = 0;
        total     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        busy_drv  = 1'b1;
        model_on  = 1'b0;
        step();
        step();
        chk("rst_send", 32'(tx_send), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_tout", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        step();

        // Pack 1,0,1,0,0,1,0,1 -> 0xA5 while the transmitter is busy.
        push_byte(8'hA5);
        chk("a5_count", 32'(fifo_count), 32'd1);
        step();
        step();
        chk("a5_nosend", 32'(sq.size()), 32'd0);
        busy_drv = 1'b0;
        wait_send(5, "a5_send");
        chk("a5_data", 32'(tx_data), 32'hA5);
        chk("a5_drained", 32'(fifo_count), 32'd0);
        busy_drv = 1'b1;
        step();

        // Handshake with the transmitter model, four bytes in order.
        sq.delete();
        tq.delete();
        model_on = 1'b1;
        for (int b = 1; b <= 4; b++) push_byte(8'(b));
        wait_q(4, 100, "seq_n");
        for (int k = 0; k < sq.size(); k++)
            chk("seq_data", 32'(sq[k]), 32'(k + 1));
        for (int k = 1; k < tq.size(); k++)
            chk("seq_gap_ge12", 32'(tq[k] - tq[k-1] >= 12), 32'd1);
        for (int i = 0; i < 30; i++) step();
        chk("seq_no_extra", 32'(sq.size()), 32'd4);
        model_on = 1'b0;
        busy_drv = 1'b1;

        // Overflow: 17 bytes into a 16-deep FIFO, then drain.
        for (int b = 0; b < 17; b++) push_byte(8'(8'h10 + b));
        chk("ovf_count", 32'(fifo_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        sq.delete();
        tq.delete();
        model_on = 1'b1;
        wait_q(16, 400, "ovf_drain_n");
        for (int k = 0; k < sq.size(); k++)
            chk("ovf_order", 32'(sq[k]), 32'(8'h10 + k));
        for (int i = 0; i < 30; i++) step();
        chk("ovf_no17", 32'(sq.size()), 32'd16);
        chk("ovf_empty", 32'(fifo_count), 32'd0);
        chk("ovf_no_tout", 32'(timeout_err), 32'd0);
        model_on = 1'b0;
        busy_drv = 1'b1;

        // Timeout: busy never rises after a send.
        push_byte(8'hC3);
        push_byte(8'h3C);
        busy_drv = 1'b0;
        wait_send(5, "to_send");
        chk("to_data", 32'(tx_data), 32'hC3);
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 63) chk("to_early", 32'(timeout_err), 32'd0);
        end
        chk("to_flag", 32'(timeout_err), 32'd1);
        step();
        chk("to_next_send", 32'(tx_send), 32'd1);
        chk("to_next_data", 32'(tx_data), 32'h3C);
        busy_drv = 1'b1;
        step();

        // Enable gating: 5 bits, paused, then 3 bits -> 0xD3.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit_valid = i[0];
            bit_in    = ~i[1];
            step();
        end
        bit_valid = 1'b0;
        chk("en_hold_count", 32'(fifo_count), 32'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("en_count", 32'(fifo_count), 32'd1);
        busy_drv = 1'b0;
        wait_send(5, "en_send");
        exp_b = 8'hD3;
        chk("en_data", 32'(tx_data), 32'(exp_b));
        busy_drv = 1'b1;
        step();

        // Reset while in ACK with three bytes still queued.
        for (int b = 0; b < 4; b++) push_byte(8'(8'h11 * (b + 1)));
        busy_drv = 1'b0;
        wait_send(5, "rs_send");
        chk("rs_queued", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rs_send0", 32'(tx_send), 32'd0);
        chk("rs_data0", 32'(tx_data), 32'h00);
        chk("rs_count0", 32'(fifo_count), 32'd0);
        chk("rs_ovf0", 32'(overflow), 32'd0);
        chk("rs_tout0", 32'(timeout_err), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        nsend = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_send) nsend++;
        end
        chk("rs_quiet", 32'(nsend), 32'd0);
        push_byte(8'h5A);
        wait_send(10, "rs_new_send");
        chk("rs_new_data", 32'(tx_data), 32'h5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
